// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for mem_port_arbiter.
//   owner_e    : which requester a granted access belongs to
//   WORD_SHIFT : byte address -> word index shift
//   rsp_t      : one-deep response pipeline entry
// Build option: ARB_ROUND_ROBIN_EN (consumed by mem_arb_pick and the top).
package mem_arb_pkg;

  localparam int WORD_SHIFT = 2;

  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
    logic   we;
  } rsp_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the arbiter.
//   if_*  : fetch port (read-only)          ls_*  : load/store port
//   mem_* : single word-addressed memory port (read data registered by memory)
// Modports: slave = arbiter view, master = requester/memory environment view.
// Build option: ARB_ROUND_ROBIN_EN does not change this interface.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_we;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;

  logic              mem_en;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, ls_we, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_we, mem_idx, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, ls_we, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err,
           mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select between fetch and load/store.
//   if_req, ls_req : pending requests
//   last_win       : previous winner (only with ARB_ROUND_ROBIN_EN)
//   if_win, ls_win : one-hot (or zero) winner
// ARB_ROUND_ROBIN_EN defined  : on conflict the previous loser wins.
// ARB_ROUND_ROBIN_EN undefined: load/store always wins a conflict.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_win,
`endif
  output logic   if_win,
  output logic   ls_win
);

  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req && ls_req) begin
      if (last_win == OWN_LS) if_win = 1'b1;
      else                    ls_win = 1'b1;
    end else begin
      if_win = if_req;
      ls_win = ls_req;
    end
`else
    ls_win = ls_req;
    if_win = if_req & ~ls_req;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-addressed memory between fetch and
// load/store. Grants are combinational, completions arrive one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (requester ports + memory port)
// Misaligned or out-of-range requests are granted but never reach memory;
// they complete with err=1 and rdata=0.
// Build option: ARB_ROUND_ROBIN_EN adds a last-winner flop for fair arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic              if_win, ls_win;
  logic              if_gnt, ls_gnt, gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;
  logic              mem_en, mem_we;
  rsp_t              rsp_q;
  logic              rsp_if, rsp_ls;
  logic [DATA_W-1:0] rsp_data;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_win_q;

  mem_arb_pick u_pick (
    .if_req   (bus.if_req),
    .ls_req   (bus.ls_req),
    .last_win (last_win_q),
    .if_win   (if_win),
    .ls_win   (ls_win)
  );

  // Reset to OWN_IF so the first conflict goes to load/store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_win_q <= OWN_IF;
    else if (gnt_any) last_win_q <= ls_gnt ? OWN_LS : OWN_IF;
  end
`else
  mem_arb_pick u_pick (
    .if_req (bus.if_req),
    .ls_req (bus.ls_req),
    .if_win (if_win),
    .ls_win (ls_win)
  );
`endif

  // Grants are combinational; gating with rst_n keeps every output low in reset.
  assign if_gnt  = if_win & rst_n;
  assign ls_gnt  = ls_win & rst_n;
  assign gnt_any = if_gnt | ls_gnt;

  always_comb begin
    sel_addr = ls_gnt ? bus.ls_addr : bus.if_addr;
    // Range check on the full word index, so high address bits never alias.
    sel_err  = (sel_addr[WORD_SHIFT-1:0] != '0) ||
               ((sel_addr >> WORD_SHIFT) >= ADDR_W'(MEM_WORDS));
    mem_en   = gnt_any & ~sel_err;
    mem_we   = mem_en & ls_gnt & bus.ls_we;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_idx   = mem_en ? sel_addr[WORD_SHIFT +: IDX_W] : '0;
  assign bus.mem_wdata = mem_we ? bus.ls_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= gnt_any;
      rsp_q.owner <= ls_gnt ? OWN_LS : OWN_IF;
      rsp_q.err   <= sel_err;
      rsp_q.we    <= ls_gnt & bus.ls_we;
    end
  end

  always_comb begin
    rsp_if   = rsp_q.valid && (rsp_q.owner == OWN_IF);
    rsp_ls   = rsp_q.valid && (rsp_q.owner == OWN_LS);
    // Memory read data only means something for a successful read.
    rsp_data = (rsp_q.valid && !rsp_q.err && !rsp_q.we) ? bus.mem_rdata : '0;
  end

  assign bus.if_rvalid = rsp_if;
  assign bus.if_rdata  = rsp_if ? rsp_data : '0;
  assign bus.if_err    = rsp_if & rsp_q.err;
  assign bus.ls_rvalid = rsp_ls;
  assign bus.ls_rdata  = rsp_ls ? rsp_data : '0;
  assign bus.ls_err    = rsp_ls & rsp_q.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random bench for mem_port_arbiter with a
// transaction-level reference model and a simple registered memory.
// Build option: ARB_ROUND_ROBIN_EN (must match the RTL build).
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, WORDS = 16, IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem_arr [WORDS] = '{
    32'h1111_0000, 32'h2222_0001, 32'h0030_8233, 32'h4444_0003,
    32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007,
    32'h9999_0008, 32'hAAAA_0009, 32'hBBBB_000A, 32'hCCCC_000B,
    32'hDDDD_000C, 32'hEEEE_000D, 32'hFFFF_000E, 32'h1234_000F};
  logic [31:0] ref_mem [WORDS] = '{
    32'h1111_0000, 32'h2222_0001, 32'h0030_8233, 32'h4444_0003,
    32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007,
    32'h9999_0008, 32'hAAAA_0009, 32'hBBBB_000A, 32'hCCCC_000B,
    32'hDDDD_000C, 32'hEEEE_000D, 32'hFFFF_000E, 32'h1234_000F};

  // Memory environment: one-cycle registered read, synchronous write.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_idx] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_idx];
    end
  end

  int nerr = 0;
  int nchk = 0;

  // Reference model state: the completion owed next cycle, fairness history.
  bit          pend_v, pend_if, pend_err;
  logic [31:0] pend_data;
  bit          last_ls;
  bit          g_if, g_ls;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= WORDS);
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 4) != 0) return 32'($urandom_range(0, WORDS - 1)) << 2;
    return 32'($urandom_range(0, 127));
  endfunction

  task automatic model_reset();
    pend_v  = 1'b0;
    pend_if = 1'b0;
    last_ls = 1'b0;
    g_if    = 1'b0;
    g_ls    = 1'b0;
  endtask

  // Called at the falling edge: compare this cycle's outputs with the model,
  // then record the transaction that the coming rising edge will launch.
  task automatic cycle_check();
    bit wl, wi, any, b, wr;
    logic [31:0] a, d;
    if (bus.if_req && bus.ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      wl = !last_ls;
`else
      wl = 1'b1;
`endif
      wi = !wl;
    end else begin
      wl = bus.ls_req;
      wi = bus.if_req;
    end
    any = wl | wi;
    a   = wl ? bus.ls_addr : bus.if_addr;
    b   = is_bad(a);
    wr  = any && !b && wl && bus.ls_we;
    chk1("if_gnt", bus.if_gnt, wi);
    chk1("ls_gnt", bus.ls_gnt, wl);
    chk1("mem_en", bus.mem_en, any && !b);
    chk1("mem_we", bus.mem_we, wr);
    chk32("mem_idx", 32'(bus.mem_idx), (any && !b) ? a / 4 : 32'd0);
    chk32("mem_wdata", bus.mem_wdata, wr ? bus.ls_wdata : 32'd0);
    chk1("if_rvalid", bus.if_rvalid, pend_v && pend_if);
    chk32("if_rdata", bus.if_rdata, (pend_v && pend_if) ? pend_data : 32'd0);
    chk1("if_err", bus.if_err, pend_v && pend_if && pend_err);
    chk1("ls_rvalid", bus.ls_rvalid, pend_v && !pend_if);
    chk32("ls_rdata", bus.ls_rdata, (pend_v && !pend_if) ? pend_data : 32'd0);
    chk1("ls_err", bus.ls_err, pend_v && !pend_if && pend_err);
    d = (any && !b && !wr) ? ref_mem[a[5:2]] : 32'd0;
    if (wr) ref_mem[a[5:2]] = bus.ls_wdata;
    pend_v    = any;
    pend_if   = wi;
    pend_err  = b;
    pend_data = d;
    if (any) last_ls = wl;
    g_if = wi;
    g_ls = wl;
  endtask

  task automatic step();
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_if_gnt"}, bus.if_gnt, 1'b0);
    chk1({tag, "_ls_gnt"}, bus.ls_gnt, 1'b0);
    chk1({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
    chk1({tag, "_ls_rvalid"}, bus.ls_rvalid, 1'b0);
    chk1({tag, "_if_err"}, bus.if_err, 1'b0);
    chk1({tag, "_ls_err"}, bus.ls_err, 1'b0);
    chk32({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk32({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
    chk1({tag, "_mem_en"}, bus.mem_en, 1'b0);
    chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk32({tag, "_mem_idx"}, 32'(bus.mem_idx), 32'd0);
    chk32({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_we    = 1'b0;
    bus.ls_wdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    apply_reset();

    // Single fetch from word 2.
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    @(negedge clk);
    chk1("t1_if_gnt", bus.if_gnt, 1'b1);
    chk32("t1_mem_idx", 32'(bus.mem_idx), 32'd2);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk1("t1_if_rvalid", bus.if_rvalid, 1'b1);
    chk32("t1_if_rdata", bus.if_rdata, 32'h0030_8233);
    chk1("t1_ls_rvalid", bus.ls_rvalid, 1'b0);
    step();

    // Store to word 3.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'hC; bus.ls_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("t2_mem_en", bus.mem_en, 1'b1);
    chk1("t2_mem_we", bus.mem_we, 1'b1);
    chk32("t2_mem_idx", 32'(bus.mem_idx), 32'd3);
    step();
    idle_inputs();
    @(negedge clk);
    chk1("t2_ls_rvalid", bus.ls_rvalid, 1'b1);
    chk32("t2_ls_rdata", bus.ls_rdata, 32'd0);
    chk1("t2_ls_err", bus.ls_err, 1'b0);
    step();

    // Contention from a fresh reset: both held for 4 cycles.
    apply_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h14;
    bus.ls_req = 1'b1; bus.ls_addr = 32'h10; bus.ls_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      chk1("t3_ls_gnt", bus.ls_gnt, (i % 2) == 0);
      chk1("t3_if_gnt", bus.if_gnt, (i % 2) == 1);
`else
      chk1("t3_ls_gnt", bus.ls_gnt, 1'b1);
      chk1("t3_if_gnt", bus.if_gnt, 1'b0);
`endif
      step();
    end
    idle_inputs();
    @(negedge clk);
    step();

    // Misaligned load, then out-of-range fetch.
    bus.ls_req = 1'b1; bus.ls_addr = 32'h6;
    @(negedge clk);
    chk1("t4_ls_gnt", bus.ls_gnt, 1'b1);
    chk1("t4_ls_mem_en", bus.mem_en, 1'b0);
    step();
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk1("t4_ls_err", bus.ls_err, 1'b1);
    chk32("t4_ls_rdata", bus.ls_rdata, 32'd0);
    chk1("t4_if_gnt", bus.if_gnt, 1'b1);
    chk1("t4_if_mem_en", bus.mem_en, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk1("t4_if_err", bus.if_err, 1'b1);
    chk32("t4_if_rdata", bus.if_rdata, 32'd0);
    step();

    // Reset while a response is in flight.
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    @(negedge clk);
    chk1("t5_if_gnt", bus.if_gnt, 1'b1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk_all_zero("t5_in_reset_a");
    @(negedge clk);
    chk_all_zero("t5_in_reset_b");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("t5_no_if_rvalid", bus.if_rvalid, 1'b0);
      step();
    end

    // Eight back-to-back fetches.
    for (int i = 0; i < 8; i++) begin
      bus.if_req = 1'b1; bus.if_addr = 32'(i * 4);
      @(negedge clk);
      if (i > 0) chk1("t6_if_rvalid_run", bus.if_rvalid, 1'b1);
      step();
    end
    idle_inputs();
    @(negedge clk);
    chk1("t6_if_rvalid_last", bus.if_rvalid, 1'b1);
    step();
    @(negedge clk);
    chk1("t6_if_rvalid_end", bus.if_rvalid, 1'b0);
    step();

    // Random traffic; a request is held until the model sees it granted.
    g_if = 1'b0;
    g_ls = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!bus.if_req || g_if) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = rnd_addr();
      end
      if (!bus.ls_req || g_ls) begin
        bus.ls_req   = ($urandom_range(0, 3) != 0);
        bus.ls_addr  = rnd_addr();
        bus.ls_we    = $urandom_range(0, 1) == 1;
        bus.ls_wdata = $urandom;
      end
      @(negedge clk);
      step();
    end
    idle_inputs();
    @(negedge clk);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single word-addressed memory between the instruction-fetch path and the load/store path of the CPU. It accepts byte-addressed requests, checks alignment and range, and issues at most one access per cycle to the memory. It returns each read or write completion one cycle after grant, tagged to the requester that issued it. The block sits between the fetch/LSU stages and the memory array.

## Interface
- ADDR_W, 32, byte-address width of requester ports
- DATA_W, 32, data width
- MEM_WORDS, 16, memory depth in words; word index width IDX_W = $clog2(MEM_WORDS)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req / ls_req  in  1  request valid (fetch / load-store); held until granted
- if_addr / ls_addr  in  ADDR_W  byte address
- ls_we  in  1  store when 1 (fetch is read-only)
- ls_wdata  in  DATA_W  store data
- if_gnt / ls_gnt  out  1  combinational grant; request accepted this cycle
- if_rvalid / ls_rvalid  out  1  completion pulse, one cycle after grant
- if_rdata / ls_rdata  out  DATA_W  read data, valid with rvalid
- if_err / ls_err  out  1  misaligned or out-of-range, valid with rvalid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_idx  out  IDX_W  word index (addr >> 2)
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, registered by memory, valid cycle after mem_en

## Operation
- Grant at most one requester per cycle; a request with no competitor is granted the same cycle it is asserted.
- Arbitration is fixed priority: ls over if. Round-robin with the macro enabled.
- Error check: addr[1:0] != 0 or (addr >> 2) >= MEM_WORDS → granted, mem_en stays 0, err=1 and rdata=0 on completion; stores with error are dropped.
- Pipeline register (rsp_valid, rsp_owner, rsp_err) captures the grant; next cycle the owner's rvalid=1. rdata comes from mem_rdata, or 0 on error or store.
- The non-owner's rvalid, rdata and err are 0.
- Back-to-back grants are allowed every cycle; there is no stall. A requester may re-request in its rvalid cycle.

## Timing
- Cycle N: req & gnt, mem_* driven. Cycle N+1: rvalid and rdata/err. Latency is 1 and throughput is 1 per cycle.
- Reset values: all gnt, rvalid, err, and mem_en/mem_we = 0; rdata, mem_idx and mem_wdata = 0; the round-robin pointer favours ls.
- Reset asserted with a response in flight: the response is discarded and no rvalid follows after release.
- Simultaneous if_req and ls_req: exactly one gnt; the loser's gnt=0 and it must hold its request.
- Address wrap: only the index bits below the range check are used; there is no modulo aliasing.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a last-winner flop is updated on every grant; on conflict the requester that did not win last is granted. This guarantees no requester waits more than 1 cycle under contention.
- ARB_ROUND_ROBIN_EN undefined: strict ls priority with no pointer flop. Fetch may starve while ls_req is held continuously.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic {OWN_IF, OWN_LS} owner_e
  - WORD_SHIFT = 2
  - the packed rsp_t struct {valid, owner, err, we}
- One sub-module, mem_arb_pick: combinational winner select with an optional pointer input. The top level holds the response pipeline and error checking.

## Test plan
- if_req only, addr 0x8, mem_rdata=0x00308233 → if_gnt same cycle, mem_idx=2; next cycle if_rvalid=1, if_rdata=0x00308233, ls_rvalid=0.
- ls_we=1 addr 0xC wdata 0xDEADBEEF → mem_en=1, mem_we=1, mem_idx=3; next cycle ls_rvalid=1, ls_rdata=0, ls_err=0.
- Both requests held 4 cycles:
  - without macro → ls_gnt every cycle, if_gnt never.
  - with macro → grants alternate LS, IF, LS, IF.
- ls addr 0x6 (misaligned) and if addr 0x40 (out of range, MEM_WORDS=16) → no mem_en; each rvalid with err=1 and rdata=0.
- Grant at cycle N, rst_n low at N+0.5 and released at N+2 → no rvalid at any point; all outputs 0 during reset.
- 8 consecutive fetches at 0x0, 0x4, … → if_rvalid high for 8 consecutive cycles starting 1 cycle after the first grant.
